bdi_compressor_seq: RTL and testbench

- Parametrised, handshaked successor to the single-shot base-delta line compressor.
- Accepts one uncompressed cache line plus tag and evaluates the BDI encodings sequentially, one per cycle.
- Emits the smallest encoding, packed, with code, byte size and a round-robin way assignment.
- Sits between the L2 fill path and the compressed data array.

---
 rtl/bdi_pkg.sv | 39 +++
 rtl/bdi_delta_check.sv | 34 +++
 rtl/bdi_compressor_seq.sv | 167 ++++++++++++++++
 tb/tb_bdi_compressor_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bdi_pkg.sv
// Shared types and helpers for the sequential base-delta-immediate line compressor.
package bdi_pkg;

    typedef enum logic [3:0] {
        ENC_ZERO   = 4'd0,
        ENC_REP8   = 4'd1,
        ENC_B8D1   = 4'd2,
        ENC_B4D1   = 4'd3,
        ENC_B8D2   = 4'd4,
        ENC_B2D1   = 4'd5,
        ENC_B4D2   = 4'd6,
        ENC_B8D4   = 4'd7,
        ENC_UNCOMP = 4'd15
    } enc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int N_ENC = 8;

    // Packed size in bytes: base width K plus one D-byte delta per K-byte element.
    function automatic int enc_size(input enc_t e, input int line_bytes);
        case (e)
            ENC_ZERO: return 1;
            ENC_REP8: return 8;
            ENC_B8D1: return 8 + (line_bytes / 8) * 1;
            ENC_B4D1: return 4 + (line_bytes / 4) * 1;
            ENC_B8D2: return 8 + (line_bytes / 8) * 2;
            ENC_B2D1: return 2 + (line_bytes / 2) * 1;
            ENC_B4D2: return 4 + (line_bytes / 4) * 2;
            ENC_B8D4: return 8 + (line_bytes / 8) * 4;
            default:  return line_bytes;
        endcase
    endfunction

endpackage

// File: rtl/bdi_delta_check.sv
// Combinational base+delta applicability test and packer for one (K, D) pairing.
module bdi_delta_check #(
    parameter int LINE_BYTES = 64,
    parameter int K          = 8,
    parameter int D          = 1
) (
    input  logic [LINE_BYTES*8-1:0] i_line,
    output logic                    o_ok,
    output logic [LINE_BYTES*8-1:0] o_data
);

    localparam int N  = LINE_BYTES / K;
    localparam int EW = 8 * K;
    localparam int DW = 8 * D;

    logic [EW-1:0] w_base;
    logic [EW-1:0] w_diff;

    // A delta fits in D signed bytes when every bit above the D-byte sign bit matches it.
    always_comb begin
        w_base         = i_line[EW-1:0];
        w_diff         = '0;
        o_ok           = 1'b1;
        o_data         = '0;
        o_data[EW-1:0] = w_base;
        for (int i = 0; i < N; i++) begin
            w_diff = i_line[i*EW +: EW] - w_base;
            if (!((&w_diff[EW-1:DW-1]) || (~|w_diff[EW-1:DW-1])))
                o_ok = 1'b0;
            o_data[(K + i*D)*8 +: DW] = w_diff[DW-1:0];
        end
    end

endmodule

// File: rtl/bdi_compressor_seq.sv
// Sequential BDI line compressor: one candidate encoding per cycle, smallest wins.
// Optional BDI_STATS_EN adds saturating line and bytes-saved counters.
module bdi_compressor_seq
    import bdi_pkg::*;
#(
    parameter  int LINE_BYTES = 64,
    parameter  int TAG_W      = 64,
    parameter  int WAYS       = 16,
    localparam int SZ_W       = $clog2(LINE_BYTES) + 1,
    localparam int WAY_W      = $clog2(WAYS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LINE_BYTES*8-1:0] in_line,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LINE_BYTES*8-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic [3:0]              out_code,
    output logic [SZ_W-1:0]         out_size,
`ifdef BDI_STATS_EN
    output logic [31:0]             stat_lines,
    output logic [31:0]             stat_bytes_saved,
`endif
    output logic [WAY_W-1:0]        out_way
);

    localparam int LW = LINE_BYTES * 8;

    state_t                     r_state;
    logic [$clog2(N_ENC)-1:0]   r_idx;
    logic [WAY_W-1:0]           r_way;
    logic [LW-1:0]              r_line;
    logic [TAG_W-1:0]           r_tag;
    logic [LW-1:0]              r_best_data;
    enc_t                       r_best_code;
    logic [SZ_W-1:0]            r_best_size;

    logic                       w_zero, w_rep8;
    logic                       w_ok_b8d1, w_ok_b4d1, w_ok_b8d2, w_ok_b2d1, w_ok_b4d2, w_ok_b8d4;
    logic [LW-1:0]              w_d_b8d1, w_d_b4d1, w_d_b8d2, w_d_b2d1, w_d_b4d2, w_d_b8d4;
    logic                       w_cand_ok, w_take;
    logic [LW-1:0]              w_cand_data;
    enc_t                       w_cand_code;
    logic [SZ_W-1:0]            w_cand_size;

    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(8), .D(1)) u_b8d1 (.i_line(r_line), .o_ok(w_ok_b8d1), .o_data(w_d_b8d1));
    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(4), .D(1)) u_b4d1 (.i_line(r_line), .o_ok(w_ok_b4d1), .o_data(w_d_b4d1));
    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(8), .D(2)) u_b8d2 (.i_line(r_line), .o_ok(w_ok_b8d2), .o_data(w_d_b8d2));
    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(2), .D(1)) u_b2d1 (.i_line(r_line), .o_ok(w_ok_b2d1), .o_data(w_d_b2d1));
    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(4), .D(2)) u_b4d2 (.i_line(r_line), .o_ok(w_ok_b4d2), .o_data(w_d_b4d2));
    bdi_delta_check #(.LINE_BYTES(LINE_BYTES), .K(8), .D(4)) u_b8d4 (.i_line(r_line), .o_ok(w_ok_b8d4), .o_data(w_d_b8d4));

    always_comb begin
        w_zero = ~|r_line;
        w_rep8 = 1'b1;
        for (int i = 1; i < LINE_BYTES / 8; i++)
            if (r_line[i*64 +: 64] != r_line[63:0])
                w_rep8 = 1'b0;
    end

    // Candidate for the current evaluation slot; the best register starts at
    // UNCOMP size, so strict less-than also rejects sizes >= LINE_BYTES.
    always_comb begin
        w_cand_ok   = 1'b0;
        w_cand_data = '0;
        w_cand_code = enc_t'({1'b0, r_idx});
        case (r_idx)
            3'd0: w_cand_ok = w_zero;
            3'd1: begin
                w_cand_ok         = w_rep8;
                w_cand_data[63:0] = r_line[63:0];
            end
            3'd2: begin w_cand_ok = w_ok_b8d1; w_cand_data = w_d_b8d1; end
            3'd3: begin w_cand_ok = w_ok_b4d1; w_cand_data = w_d_b4d1; end
            3'd4: begin w_cand_ok = w_ok_b8d2; w_cand_data = w_d_b8d2; end
            3'd5: begin w_cand_ok = w_ok_b2d1; w_cand_data = w_d_b2d1; end
            3'd6: begin w_cand_ok = w_ok_b4d2; w_cand_data = w_d_b4d2; end
            default: begin w_cand_ok = w_ok_b8d4; w_cand_data = w_d_b8d4; end
        endcase
        w_cand_size = SZ_W'(enc_size(w_cand_code, LINE_BYTES));
        w_take      = w_cand_ok && (w_cand_size < r_best_size);
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            r_line      <= in_line;
            r_tag       <= in_tag;
            r_best_data <= in_line;
        end else if (r_state == EVAL && w_take) begin
            r_best_data <= w_cand_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_way       <= '0;
            r_best_code <= ENC_UNCOMP;
            r_best_size <= SZ_W'(LINE_BYTES);
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_code    <= '0;
            out_size    <= '0;
            out_way     <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid && in_ready) begin
                    r_best_code <= ENC_UNCOMP;
                    r_best_size <= SZ_W'(LINE_BYTES);
                    r_idx       <= '0;
                    in_ready    <= 1'b0;
                    r_state     <= EVAL;
                end
                EVAL: begin
                    if (w_take) begin
                        r_best_code <= w_cand_code;
                        r_best_size <= w_cand_size;
                    end
                    if (r_idx == 3'(N_ENC - 1)) begin
                        out_valid <= 1'b1;
                        out_data  <= w_take ? w_cand_data : r_best_data;
                        out_code  <= w_take ? w_cand_code : r_best_code;
                        out_size  <= w_take ? w_cand_size : r_best_size;
                        out_tag   <= r_tag;
                        out_way   <= r_way;
                        r_state   <= OUT;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_way     <= r_way + WAY_W'(1);
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BDI_STATS_EN
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lines       <= '0;
            stat_bytes_saved <= '0;
        end else if (out_valid && out_ready) begin
            stat_lines       <= sat_add32(stat_lines, 32'd1);
            stat_bytes_saved <= sat_add32(stat_bytes_saved, 32'(LINE_BYTES) - 32'(out_size));
        end
    end
`endif

endmodule

// File: tb/tb_bdi_compressor_seq.sv
// Randomised bench for bdi_compressor_seq against a byte-level behavioural model.
module tb_bdi_compressor_seq;

    localparam int LB = 64;
    localparam int LW = LB * 8;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, out_valid, out_ready;
    logic [LW-1:0] in_line, out_data;
    logic [63:0]   in_tag, out_tag;
    logic [3:0]    out_code;
    logic [6:0]    out_size;
    logic [3:0]    out_way;

    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_way  = 0;
    int            obs_code, obs_size;
    logic [LW-1:0] obs_data;

    always #5 clk = ~clk;

    bdi_compressor_seq #(.LINE_BYTES(LB), .TAG_W(64), .WAYS(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_code(out_code), .out_size(out_size), .out_way(out_way)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic longint unsigned elem(input logic [LW-1:0] l, input int j, input int k);
        longint unsigned e = 0;
        for (int b = 0; b < k; b++) e = e | (longint'(l[8*(j*k+b) +: 8]) << (8*b));
        return e;
    endfunction

    function automatic longint sext(input longint unsigned v, input int bits);
        if (bits >= 64) return longint'(v);
        v = v & ((64'd1 << bits) - 64'd1);
        if (v >= (64'd1 << (bits-1))) return longint'(v) - longint'(64'd1 << bits);
        return longint'(v);
    endfunction

    // Walks the candidates in priority order; earlier codes win ties.
    function automatic void ref_model(input logic [LW-1:0] line, output int code,
                                      output int size, output logic [LW-1:0] data);
        int kk[8];
        int dd[8];
        int k, d, csz;
        bit ok;
        longint unsigned b0;
        longint s, lim;
        logic [LW-1:0] cdat;
        kk = '{0, 0, 8, 4, 8, 2, 4, 8};
        dd = '{0, 0, 1, 1, 2, 1, 2, 4};
        code = 15; size = LB; data = line;
        for (int c = 0; c < 8; c++) begin
            cdat = '0; ok = 1'b1;
            if (c == 0) begin
                ok = (line == '0); csz = 1;
            end else if (c == 1) begin
                csz = 8;
                for (int i = 1; i < LB / 8; i++) if (line[64*i +: 64] != line[63:0]) ok = 1'b0;
                cdat[63:0] = line[63:0];
            end else begin
                k = kk[c]; d = dd[c];
                csz = k + (LB / k) * d;
                lim = longint'(1) << (8*d - 1);
                b0 = elem(line, 0, k);
                for (int b = 0; b < k; b++) cdat[8*b +: 8] = line[8*b +: 8];
                for (int j = 0; j < LB / k; j++) begin
                    s = sext(elem(line, j, k) - b0, 8*k);
                    if (s < -lim || s >= lim) ok = 1'b0;
                    for (int m = 0; m < d; m++) cdat[8*(k + j*d + m) +: 8] = 8'(s >> (8*m));
                end
            end
            if (ok && csz < LB && csz < size) begin
                code = c; size = csz; data = cdat;
            end
        end
    endfunction

    function automatic logic [LW-1:0] gen_line(input int kind);
        logic [LW-1:0] l;
        logic [63:0] w;
        int k, d;
        longint unsigned base, e;
        longint dv;
        l = rand_line();
        case (kind)
            0: l = '0;
            1: begin
                w = {$urandom, $urandom};
                for (int i = 0; i < LB / 8; i++) l[64*i +: 64] = w;
            end
            2: begin
                k = (1 << $urandom_range(1, 3));
                d = (k == 2) ? 1 : (1 << $urandom_range(0, (k == 4) ? 1 : 2));
                base = {$urandom, $urandom};
                for (int j = 0; j < LB / k; j++) begin
                    dv = (j == 0) ? 0 : longint'($urandom_range(0, 255)) - 128;
                    if (d > 1 && j != 0) dv = dv * longint'($urandom_range(1, 100));
                    e = base + longint'(dv);
                    for (int b = 0; b < k; b++) l[8*(j*k+b) +: 8] = 8'(e >> (8*b));
                end
            end
            default: ;
        endcase
        return l;
    endfunction

    task automatic do_line(input logic [LW-1:0] line, input logic [63:0] tag, input int stall);
        int ecode, esize, lat;
        logic [LW-1:0] edata;
        ref_model(line, ecode, esize, edata);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1; in_line = line; in_tag = tag;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_line = rand_line(); in_tag = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 8);
        obs_code = out_code; obs_size = out_size; obs_data = out_data;
        chk("code", out_code, ecode);
        chk("size", out_size, esize);
        chk("data", out_data, edata);
        chk("tag", out_tag, tag);
        chk("way", out_way, exp_way);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_data", out_data, edata);
            chk("stall_code", out_code, ecode);
            chk("stall_way", out_way, exp_way);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
        exp_way = (exp_way + 1) % 16;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [LW-1:0] l, ex;
        reset = 1'b1; in_valid = 1'b0; in_line = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_size", out_size, 0);
        chk("rst_out_way", out_way, 0);
        reset = 1'b0;

        do_line('0, 64'h1, 0);
        chk("zero_code", obs_code, 0);
        chk("zero_size", obs_size, 1);
        chk("zero_data", obs_data, 0);

        for (int i = 0; i < 8; i++) l[64*i +: 64] = 64'hAB00AB01AB02AB03;
        do_line(l, 64'h2, 0);
        ex = '0; ex[63:0] = 64'hAB00AB01AB02AB03;
        chk("rep8_code", obs_code, 1);
        chk("rep8_size", obs_size, 8);
        chk("rep8_data", obs_data, ex);

        for (int i = 0; i < 8; i++) l[64*i +: 64] = 64'h1000 + 64'(i);
        do_line(l, 64'h3, 0);
        ex = '0; ex[63:0] = 64'h1000; ex[127:64] = 64'h0706050403020100;
        chk("b8d1_code", obs_code, 2);
        chk("b8d1_size", obs_size, 16);
        chk("b8d1_data", obs_data, ex);

        for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h0001_0000 + 32'(300 * i);
        do_line(l, 64'h4, 0);
        chk("b4d2_code", obs_code, 6);
        chk("b4d2_size", obs_size, 36);

        l = rand_line();
        do_line(l, 64'h5, 0);
        chk("uncomp_code", obs_code, 15);
        chk("uncomp_size", obs_size, 64);
        chk("uncomp_data", obs_data, l);

        do_line(gen_line(2), 64'h6, 5);

        for (int n = 0; n < 17; n++)
            do_line(gen_line(int'($urandom_range(0, 3))), {$urandom, $urandom}, 0);

        @(negedge clk);
        in_valid = 1'b1; in_line = gen_line(1); in_tag = 64'hDEAD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_output", out_valid, 0);
        exp_way = 0;
        do_line(gen_line(2), 64'h7, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
